// File: rtl/inference_scheduler.sv
// inference_scheduler: sequences received frames through the inference accelerator and hands replies to transmit
//
// Ports:
//   ACLK, ARESET               clock (rising edge) and asynchronous active-low reset
//   FRAME_READY                rx datapath holds a complete frame (level, held until RX_RELEASE)
//   PACKET_FOR_ACCELERATOR     held frame targets this accelerator
//   SRC_IP/MAC_ADDRESS         requester addressing, valid while FRAME_READY
//   RX_RELEASE                 one-cycle pulse freeing the rx frame buffer
//   ACCEL_START / ACCEL_ABORT  one-cycle pulses to the accelerator
//   ACCEL_DONE, ACCEL_RESULT   completion pulse with its result
//   TX_VALID/TX_READY          reply handshake; TX_DST_* and TX_RESULT form the payload
//   BUSY                       high whenever the FSM is not IDLE
//   PROCESSED/DROPPED/TIMEOUT_COUNT  saturating statistics
//
// Optional feature: define INFERENCE_SCHED_WATCHDOG_EN to build the RUN-state
// watchdog; without it RUN waits forever and ACCEL_ABORT/TIMEOUT_COUNT are 0.
module inference_scheduler #(
  parameter int IP_ADDR_WIDTH  = 32,
  parameter int MAC_ADDR_WIDTH = 48,
  parameter int RESULT_WIDTH   = 8,
  parameter int COUNTER_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      FRAME_READY,
  input  logic                      PACKET_FOR_ACCELERATOR,
  input  logic [IP_ADDR_WIDTH-1:0]  SRC_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0] SRC_MAC_ADDRESS,
  output logic                      RX_RELEASE,
  output logic                      ACCEL_START,
  input  logic                      ACCEL_DONE,
  input  logic [RESULT_WIDTH-1:0]   ACCEL_RESULT,
  output logic                      ACCEL_ABORT,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic [IP_ADDR_WIDTH-1:0]  TX_DST_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0] TX_DST_MAC_ADDRESS,
  output logic [RESULT_WIDTH-1:0]   TX_RESULT,
  output logic                      BUSY,
  output logic [COUNTER_WIDTH-1:0]  PROCESSED_COUNT,
  output logic [COUNTER_WIDTH-1:0]  DROPPED_COUNT,
  output logic [COUNTER_WIDTH-1:0]  TIMEOUT_COUNT
);
  typedef enum logic [1:0] {IDLE, START, RUN, REPLY} state_t;
  state_t state;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 24'hFF_FFFF) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..2^24-1");
  end
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
`ifdef INFERENCE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd;
  logic expired;
  assign expired = wd == WD_LAST;
`else
  assign ACCEL_ABORT   = 1'b0;
  assign TIMEOUT_COUNT = '0;
`endif
  assign BUSY = state != IDLE;
  // The rx frame stays presented during the release cycle, so IDLE ignores
  // FRAME_READY while RX_RELEASE is high to avoid handling one frame twice.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state              <= IDLE;
      RX_RELEASE         <= 1'b0;
      ACCEL_START        <= 1'b0;
      TX_VALID           <= 1'b0;
      TX_DST_IP_ADDRESS  <= '0;
      TX_DST_MAC_ADDRESS <= '0;
      TX_RESULT          <= '0;
      PROCESSED_COUNT    <= '0;
      DROPPED_COUNT      <= '0;
`ifdef INFERENCE_SCHED_WATCHDOG_EN
      ACCEL_ABORT        <= 1'b0;
      TIMEOUT_COUNT      <= '0;
      wd                 <= '0;
`endif
    end else begin
      RX_RELEASE  <= 1'b0;
      ACCEL_START <= 1'b0;
`ifdef INFERENCE_SCHED_WATCHDOG_EN
      ACCEL_ABORT <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (FRAME_READY && !RX_RELEASE) begin
            if (PACKET_FOR_ACCELERATOR) begin
              TX_DST_IP_ADDRESS  <= SRC_IP_ADDRESS;
              TX_DST_MAC_ADDRESS <= SRC_MAC_ADDRESS;
              ACCEL_START        <= 1'b1;
              state              <= START;
            end else begin
              RX_RELEASE    <= 1'b1;
              DROPPED_COUNT <= sat_inc(DROPPED_COUNT);
            end
          end
        end
        START: begin
`ifdef INFERENCE_SCHED_WATCHDOG_EN
          wd <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          // Done is tested first so it wins over a simultaneous expiry.
          if (ACCEL_DONE) begin
            TX_RESULT  <= ACCEL_RESULT;
            RX_RELEASE <= 1'b1;
            TX_VALID   <= 1'b1;
            state      <= REPLY;
          end
`ifdef INFERENCE_SCHED_WATCHDOG_EN
          else if (expired) begin
            ACCEL_ABORT   <= 1'b1;
            RX_RELEASE    <= 1'b1;
            TIMEOUT_COUNT <= sat_inc(TIMEOUT_COUNT);
            state         <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        REPLY: begin
          if (TX_READY) begin
            TX_VALID        <= 1'b0;
            PROCESSED_COUNT <= sat_inc(PROCESSED_COUNT);
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
